// File: rtl/snn_step_sequencer_if.sv
// rtl/snn_step_sequencer_if.sv - host control, event RAM, core and spike-row bundle
interface snn_step_sequencer_if #(
  parameter int F   = 48,
  parameter int N   = 96,
  parameter int EAW = 16
);
  logic           start;
  logic [EAW:0]   t_len;
  logic           abort;
  logic           ev_rd_en;
  logic [EAW-1:0] ev_rd_addr;
  logic [F-1:0]   ev_rd_data;
  logic           core_clear;
  logic           core_step;
  logic [F-1:0]   event_vec;
  logic [N-1:0]   spikes_vec;
  logic           row_valid;
  logic           row_ready;
  logic [N-1:0]   row_data;
  logic [EAW-1:0] row_idx;
  logic           busy;
  logic           done;

  modport master (
    input  start, t_len, abort, ev_rd_data, spikes_vec, row_ready,
    output ev_rd_en, ev_rd_addr, core_clear, core_step, event_vec,
           row_valid, row_data, row_idx, busy, done
  );

  modport slave (
    output start, t_len, abort, ev_rd_data, spikes_vec, row_ready,
    input  ev_rd_en, ev_rd_addr, core_clear, core_step, event_vec,
           row_valid, row_data, row_idx, busy, done
  );
endinterface

// File: rtl/snn_step_sequencer.sv
// rtl/snn_step_sequencer.sv - steps snn_core one timestep at a time and streams spike rows
module snn_step_sequencer #(
  parameter int F        = 48,
  parameter int N        = 96,
  parameter int EAW      = 16,
  parameter int CORE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  snn_step_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_STEP, S_WAIT, S_EMIT, S_FIN
  } state_e;

  localparam logic [3:0] LAT = 4'(CORE_LAT);

  state_e         state_q, state_d;
  logic [EAW:0]   t_q, t_d;
  logic [EAW:0]   tlen_q, tlen_d;
  logic [EAW:0]   t_inc;
  logic [3:0]     wait_q;
  logic           handshake;
  logic           abort_hit;

  logic           ev_rd_en_q;
  logic [EAW-1:0] ev_rd_addr_q;
  logic           core_clear_q;
  logic           core_step_q;
  logic [F-1:0]   event_vec_q;
  logic           row_valid_q;
  logic [N-1:0]   row_data_q;
  logic [EAW-1:0] row_idx_q;
  logic           busy_q;
  logic           done_q;

  assign t_inc     = t_q + 1'b1;
  assign handshake = (state_q == S_EMIT) && row_valid_q && bus.row_ready;
  assign abort_hit = bus.abort && (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    tlen_d  = tlen_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tlen_d  = bus.t_len;
          t_d     = '0;
          state_d = (bus.t_len == '0) ? S_FIN : S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_STEP;
      S_STEP:  state_d = S_WAIT;
      S_WAIT:  if (wait_q <= 4'd1) state_d = S_EMIT;
      S_EMIT: begin
        if (handshake) begin
          t_d     = t_inc;
          state_d = (t_inc == tlen_q) ? S_FIN : S_FETCH;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A row handshaken in the abort cycle still counts, so t_d keeps the increment.
    if (abort_hit) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      tlen_q       <= '0;
      wait_q       <= '0;
      ev_rd_en_q   <= 1'b0;
      ev_rd_addr_q <= '0;
      core_clear_q <= 1'b0;
      core_step_q  <= 1'b0;
      event_vec_q  <= '0;
      row_valid_q  <= 1'b0;
      row_data_q   <= '0;
      row_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      tlen_q  <= tlen_d;

      // Strobes are registered from the next state so they coincide with their state.
      core_clear_q <= (state_d == S_CLEAR);
      ev_rd_en_q   <= (state_d == S_FETCH);
      core_step_q  <= (state_d == S_STEP);
      if (state_d == S_FETCH) ev_rd_addr_q <= t_d[EAW-1:0];

      busy_q <= (state_d != S_IDLE) || ((state_q == S_FIN) && !bus.abort);
      done_q <= (state_q == S_FIN) && !bus.abort;

      case (state_q)
        S_LOAD: event_vec_q <= bus.ev_rd_data;
        S_STEP: wait_q <= LAT;
        S_WAIT: begin
          wait_q <= wait_q - 4'd1;
          if (wait_q <= 4'd1) begin
            row_data_q  <= bus.spikes_vec;
            row_idx_q   <= t_q[EAW-1:0];
            row_valid_q <= 1'b1;
          end
        end
        S_EMIT: if (handshake) row_valid_q <= 1'b0;
        S_FIN:  event_vec_q <= '0;
        default: ;
      endcase

      if (abort_hit) begin
        event_vec_q <= '0;
        row_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ev_rd_en   = ev_rd_en_q;
  assign bus.ev_rd_addr = ev_rd_addr_q;
  assign bus.core_clear = core_clear_q;
  assign bus.core_step  = core_step_q;
  assign bus.event_vec  = event_vec_q;
  assign bus.row_valid  = row_valid_q;
  assign bus.row_data   = row_data_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
